// File: rtl/solo_squash_input_conditioner_pkg.sv
// Shared constants for the solo_squash input conditioner: button index map,
// default timing parameters and the debounce counter sizing helper.
`ifndef SOLO_SQUASH_DEFS_VH
`define SOLO_SQUASH_DEFS_VH
`define BTN_PAUSE    0
`define BTN_NEW_GAME 1
`define BTN_DOWN     2
`define BTN_UP       3
`define NUM_BTN      4
`endif

package solo_squash_input_conditioner_pkg;

  localparam int BTN_PAUSE    = `BTN_PAUSE;
  localparam int BTN_NEW_GAME = `BTN_NEW_GAME;
  localparam int BTN_DOWN     = `BTN_DOWN;
  localparam int BTN_UP       = `BTN_UP;
  localparam int BTN_COUNT    = `NUM_BTN;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

  // Counter must hold 0 .. DEBOUNCE_CYCLES-1; sized on DEBOUNCE_CYCLES+1 so
  // that DEBOUNCE_CYCLES=1 still yields a 1-bit counter.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/solo_squash_debounce.sv
// Single-channel synchroniser plus debouncer with registered level and
// one-cycle fall/rise pulses on each accepted level change.
module solo_squash_debounce
  import solo_squash_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit RESET_VAL       = 1'b1,
  parameter bit FAST_FALL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic level,
  output logic fall_pulse,
  output logic rise_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   st_reg;
  logic                   st_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   fall_reg;
  logic                   fall_next;
  logic                   rise_reg;
  logic                   rise_next;
  logic                   s;

  // Plain shift chain: nothing may sit between the metastability flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_comb begin
    st_next   = st_reg;
    cnt_next  = '0;
    fall_next = 1'b0;
    rise_next = 1'b0;
    if (s != st_reg) begin
      // FAST_FALL channels accept a low immediately and only debounce the
      // return high, giving a sticky assert for reset-style inputs.
      if (FAST_FALL && !s) begin
        st_next   = 1'b0;
        fall_next = 1'b1;
      end else if (cnt_reg == CNT_MAX) begin
        st_next   = s;
        fall_next = !s;
        rise_next = s;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_reg   <= RESET_VAL;
      cnt_reg  <= '0;
      fall_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      st_reg   <= st_next;
      cnt_reg  <= cnt_next;
      fall_reg <= fall_next;
      rise_reg <= rise_next;
    end
  end

  assign sync       = s;
  assign level      = st_reg;
  assign fall_pulse = fall_reg;
  assign rise_pulse = rise_reg;

endmodule

// File: rtl/solo_squash_input_conditioner.sv
// Conditions the raw solo_squash GPIO inputs: debounced button levels with
// press/release pulses, and a registered fast-assert/slow-release ext_reset.
module solo_squash_input_conditioner
  import solo_squash_input_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = BTN_COUNT,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n_raw,
  input  logic               ext_reset_n_raw,
  output logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               ext_reset
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("solo_squash_input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("solo_squash_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NUM_BTN-1:0] btn_sync_unused;
  logic [1:0]         ext_pulse_unused;
  logic               s_ext;
  logic               st_ext;
  logic               ext_reset_reg;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    solo_squash_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1),
      .FAST_FALL      (1'b0)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .raw       (btn_n_raw[gi]),
      .sync      (btn_sync_unused[gi]),
      .level     (btn_n[gi]),
      .fall_pulse(btn_press[gi]),
      .rise_pulse(btn_release[gi])
    );
  end

  // The ext channel resets to the asserted (low) state so ext_reset stays
  // high until a clean, debounced release is seen after reset.
  solo_squash_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b0),
    .FAST_FALL      (1'b1)
  ) u_ext_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw       (ext_reset_n_raw),
    .sync      (s_ext),
    .level     (st_ext),
    .fall_pulse(ext_pulse_unused[0]),
    .rise_pulse(ext_pulse_unused[1])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_reset_reg <= 1'b1;
    end else begin
      ext_reset_reg <= ~s_ext | ~st_ext;
    end
  end

  assign ext_reset = ext_reset_reg;

endmodule

// File: tb/tb_solo_squash_input_conditioner.sv
// Directed, table-driven bench for solo_squash_input_conditioner with
// SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
module tb_solo_squash_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n_raw;
  logic       ext_reset_n_raw;
  logic [3:0] btn_n;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       ext_reset;

  int checks   = 0;
  int failures = 0;

  solo_squash_input_conditioner #(
    .NUM_BTN        (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_n_raw      (btn_n_raw),
    .ext_reset_n_raw(ext_reset_n_raw),
    .btn_n          (btn_n),
    .btn_press      (btn_press),
    .btn_release    (btn_release),
    .ext_reset      (ext_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b;
    logic       e;
    logic       r;
    logic [3:0] exp_n;
    logic [3:0] exp_p;
    logic [3:0] exp_r;
    logic       exp_ext;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic e, input logic r);
    btn_n_raw       = b;
    ext_reset_n_raw = e;
    reset           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] en, input logic [3:0] ep,
                         input logic [3:0] er, input logic ee);
    chk({tag, ".btn_n"}, btn_n, en);
    chk({tag, ".btn_press"}, btn_press, ep);
    chk({tag, ".btn_release"}, btn_release, er);
    chk({tag, ".ext_reset"}, {3'b000, ext_reset}, {3'b000, ee});
  endtask

  task automatic set_vec(input int i, input logic [3:0] b, input logic e, input logic r,
                         input logic [3:0] en, input logic [3:0] ep, input logic [3:0] er,
                         input logic ee);
    vecs[i].b = b; vecs[i].e = e; vecs[i].r = r;
    vecs[i].exp_n = en; vecs[i].exp_p = ep; vecs[i].exp_r = er; vecs[i].exp_ext = ee;
  endtask

  initial begin
    int presses;

    // Tests 1 and 2: reset, ext release timing, press/release of btn 3.
    for (int i = 0; i < 3; i++) set_vec(i, 4'hF, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1);
    for (int i = 3; i < 9; i++) set_vec(i, 4'hF, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b1);
    set_vec(9, 4'hF, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int i = 10; i < 15; i++) set_vec(i, 4'h7, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    set_vec(15, 4'h7, 1'b1, 1'b0, 4'h7, 4'h8, 4'h0, 1'b0);
    set_vec(16, 4'h7, 1'b1, 1'b0, 4'h7, 4'h0, 4'h0, 1'b0);
    for (int i = 17; i < 22; i++) set_vec(i, 4'hF, 1'b1, 1'b0, 4'h7, 4'h0, 4'h0, 1'b0);
    set_vec(22, 4'hF, 1'b1, 1'b0, 4'hF, 4'h0, 4'h8, 1'b0);
    set_vec(23, 4'hF, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].b, vecs[i].e, vecs[i].r);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_p, vecs[i].exp_r,
              vecs[i].exp_ext);
      $display("vec %0d: b=%h e=%b r=%b -> btn_n=%h press=%h release=%h ext_reset=%b",
               i, vecs[i].b, vecs[i].e, vecs[i].r, btn_n, btn_press, btn_release, ext_reset);
    end

    // Test 3: bouncing btn 0 (2-cycle runs) never gets accepted.
    for (int i = 0; i < 28; i++) begin
      logic b0;
      b0 = (i >= 20) ? 1'b1 : (((i / 2) % 2) == 1);
      step({3'b111, b0}, 1'b1, 1'b0);
      chk_all($sformatf("bounce%0d", i), 4'hF, 4'h0, 4'h0, 1'b0);
      $display("bounce %0d: raw0=%b btn_n=%h press=%h release=%h", i, b0, btn_n,
               btn_press, btn_release);
    end

    // Test 4: one-cycle ext glitch asserts fast, releases only after debounce.
    step(4'hF, 1'b0, 1'b0);
    chk("glitch.edge1", {3'b000, ext_reset}, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      step(4'hF, 1'b1, 1'b0);
      chk($sformatf("glitch.high_edge%0d", k), {3'b000, ext_reset},
          {3'b000, (k >= 2 && k <= 6)});
      $display("glitch: high edge %0d ext_reset=%b", k, ext_reset);
    end

    // Test 5: reset mid-count discards progress on btn 1.
    for (int k = 1; k <= 4; k++) begin
      step(4'hD, 1'b1, 1'b0);
      chk_all($sformatf("midcnt%0d", k), 4'hF, 4'h0, 4'h0, 1'b0);
    end
    step(4'hD, 1'b1, 1'b1);
    chk_all("midcnt.reset", 4'hF, 4'h0, 4'h0, 1'b1);
    presses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(4'hD, 1'b1, 1'b0);
      if (btn_press[1]) presses++;
      chk_all($sformatf("midcnt.post%0d", k), (k >= 6) ? 4'hD : 4'hF,
              (k == 6) ? 4'h2 : 4'h0, 4'h0, (k <= 6));
      $display("midcnt: post-reset edge %0d btn_n=%h press=%h ext_reset=%b", k, btn_n,
               btn_press, ext_reset);
    end
    chk("midcnt.press_count", 4'(presses), 4'd1);
    for (int k = 1; k <= 8; k++) begin
      step(4'hF, 1'b1, 1'b0);
      chk($sformatf("midcnt.release%0d", k), btn_release, (k == 6) ? 4'h2 : 4'h0);
    end

    // Test 6: all buttons fall together, then rise together.
    for (int k = 1; k <= 7; k++) begin
      step(4'h0, 1'b1, 1'b0);
      chk_all($sformatf("all_fall%0d", k), (k >= 6) ? 4'h0 : 4'hF,
              (k == 6) ? 4'hF : 4'h0, 4'h0, 1'b0);
      $display("all_fall edge %0d: btn_n=%h press=%h", k, btn_n, btn_press);
    end
    for (int k = 1; k <= 7; k++) begin
      step(4'hF, 1'b1, 1'b0);
      chk_all($sformatf("all_rise%0d", k), (k >= 6) ? 4'hF : 4'h0, 4'h0,
              (k == 6) ? 4'hF : 4'h0, 1'b0);
      $display("all_rise edge %0d: btn_n=%h release=%h", k, btn_n, btn_release);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
